// File: rtl/lcd_text_refresher.sv
// Character frame buffer that redraws itself onto an lcd16x2 controller, one DDRAM address command per row.
// Optional LCD_TEXT_AUTO_REFRESH_EN: any in-range buffer write schedules a redraw without refresh_i.
module lcd_text_refresher #(
   parameter int          NUM_COLS         = 16,
   parameter int          NUM_ROWS         = 2,
   parameter logic [31:0] ROW_OFFSETS      = 32'h54144000,
   parameter logic [7:0]  LCD_SETDDRAMADDR = 8'h80,
   parameter logic [1:0]  OPS_CHAR         = 2'd1,
   parameter logic [1:0]  OPS_CMD          = 2'd3,
   parameter int          ADDR_W           = $clog2(NUM_COLS * NUM_ROWS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic              refresh_i,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic [7:0]        lcd_data_o,
   output logic [1:0]        lcd_ops_o,
   output logic              lcd_enb_o,
   input  logic              lcd_rdy_i
);
   localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;
   localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [7:0] BLANK = 8'h20;

   typedef enum logic [1:0] {IDLE, ROW_ADDR, CHAR, DONE} state_t;
   typedef enum logic [1:0] {H_REQ, H_ACK, H_FIN} hs_t;

   state_t           state_q;
   hs_t              hs_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic             pending_q;
   logic             wr_hit;
   logic             start;
   logic             last_col;
   logic             last_row;
   logic [ADDR_W-1:0] rd_idx;
   logic [7:0]       rd_data;
   logic [7:0]       row_cmd;

   // Entries hold (character ^ space) so all-zero power-up storage reads back as blanks.
   logic [7:0] buf_q [NUM_CELLS];

   assign wr_hit   = wr_en_i && (int'(wr_addr_i) < NUM_CELLS);
   assign rd_idx   = ADDR_W'(int'(row_q) * NUM_COLS + int'(col_q));
   assign rd_data  = buf_q[rd_idx] ^ BLANK;
   assign row_cmd  = LCD_SETDDRAMADDR | ROW_OFFSETS[8*int'(row_q) +: 8];
   assign last_col = (int'(col_q) == NUM_COLS - 1);
   assign last_row = (int'(row_q) == NUM_ROWS - 1);

   always_ff @(posedge clk_i) begin
      if (wr_hit) buf_q[wr_addr_i] <= wr_data_i ^ BLANK;
   end

`ifdef LCD_TEXT_AUTO_REFRESH_EN
   logic dirty_q;

   assign start = refresh_i || pending_q || dirty_q;

   // A frame that starts now reads every cell later, so it already covers a write landing this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dirty_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         dirty_q <= 1'b0;
      end else if (wr_hit) begin
         dirty_q <= 1'b1;
      end
   end
`else
   assign start = refresh_i || pending_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         hs_q         <= H_REQ;
         row_q        <= '0;
         col_q        <= '0;
         pending_q    <= 1'b0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         lcd_enb_o    <= 1'b0;
         lcd_data_o   <= 8'h00;
         lcd_ops_o    <= 2'b00;
      end else begin
         frame_done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ROW_ADDR;
                  hs_q      <= H_REQ;
                  busy_o    <= 1'b1;
                  row_q     <= '0;
                  col_q     <= '0;
                  pending_q <= 1'b0;
               end
            end
            ROW_ADDR, CHAR: begin
               if (refresh_i) pending_q <= 1'b1;
               case (hs_q)
                  H_REQ: begin
                     if (lcd_rdy_i) begin
                        lcd_data_o <= (state_q == ROW_ADDR) ? row_cmd : rd_data;
                        lcd_ops_o  <= (state_q == ROW_ADDR) ? OPS_CMD : OPS_CHAR;
                        lcd_enb_o  <= 1'b1;
                        hs_q       <= H_ACK;
                     end
                  end
                  H_ACK: begin
                     if (!lcd_rdy_i) begin
                        lcd_enb_o <= 1'b0;
                        hs_q      <= H_FIN;
                     end
                  end
                  H_FIN: begin
                     if (lcd_rdy_i) begin
                        hs_q <= H_REQ;
                        if (state_q == ROW_ADDR) begin
                           state_q <= CHAR;
                        end else if (!last_col) begin
                           col_q <= col_q + 1'b1;
                        end else if (!last_row) begin
                           row_q   <= row_q + 1'b1;
                           col_q   <= '0;
                           state_q <= ROW_ADDR;
                        end else begin
                           state_q      <= DONE;
                           frame_done_o <= 1'b1;
                           busy_o       <= 1'b0;
                        end
                     end
                  end
                  default: hs_q <= H_REQ;
               endcase
            end
            DONE: begin
               if (refresh_i) pending_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_text_refresher.sv
// Bench for lcd_text_refresher: a 2x16 and a 4x20 instance, each driven against a randomized lcd16x2 rdy model.
`timescale 1ns/1ps
module tb_lcd_text_refresher;
   localparam logic [1:0] OPS_CHAR = 2'd1;
   localparam logic [1:0] OPS_CMD  = 2'd3;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       wr_en   [2];
   logic [6:0] wr_addr [2];
   logic [7:0] wr_data [2];
   logic       refresh [2];
   logic       busy    [2];
   logic       done    [2];
   logic [7:0] ldata   [2];
   logic [1:0] lops    [2];
   logic       enb     [2];
   logic       rdy     [2];
   logic       hold    [2];
   int         busy_cnt[2];
   int         done_cnt[2] = '{0, 0};
   logic [9:0] log_a[$];
   logic [9:0] log_b[$];
   logic [7:0] mem [2][80];
   logic [7:0] row_off [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
   int         n_total = 0;
   int         n_bad   = 0;

   always #5 clk_i = ~clk_i;

   lcd_text_refresher u_a (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0][4:0]), .wr_data_i(wr_data[0]),
      .refresh_i(refresh[0]), .busy_o(busy[0]), .frame_done_o(done[0]),
      .lcd_data_o(ldata[0]), .lcd_ops_o(lops[0]), .lcd_enb_o(enb[0]), .lcd_rdy_i(rdy[0])
   );

   lcd_text_refresher #(.NUM_COLS(20), .NUM_ROWS(4)) u_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1]),
      .refresh_i(refresh[1]), .busy_o(busy[1]), .frame_done_o(done[1]),
      .lcd_data_o(ldata[1]), .lcd_ops_o(lops[1]), .lcd_enb_o(enb[1]), .lcd_rdy_i(rdy[1])
   );

   // lcd16x2 stand-in: accept on enb while ready, then stay busy for a random 1-4 cycles.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) begin
            rdy[i]      <= 1'b1;
            busy_cnt[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (rdy[i] && enb[i]) begin
               if (i == 0) log_a.push_back({lops[i], ldata[i]});
               else        log_b.push_back({lops[i], ldata[i]});
               rdy[i]      <= 1'b0;
               busy_cnt[i] <= int'($urandom_range(1, 4));
            end else if (!rdy[i]) begin
               if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
               else if (!hold[i])   rdy[i] <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int rows_of(input int inst);
      return (inst == 0) ? 2 : 4;
   endfunction

   function automatic int cols_of(input int inst);
      return (inst == 0) ? 16 : 20;
   endfunction

   // Expected frame straight from the display rules: per row one address command, then its characters.
   function automatic void build_frame(input int inst, output logic [9:0] q[$]);
      q = {};
      for (int r = 0; r < rows_of(inst); r++) begin
         q.push_back({OPS_CMD, 8'h80 | row_off[r]});
         for (int c = 0; c < cols_of(inst); c++)
            q.push_back({OPS_CHAR, mem[inst][r * cols_of(inst) + c]});
      end
   endfunction

   task automatic clear_log(input int inst);
      if (inst == 0) log_a.delete();
      else           log_b.delete();
   endtask

   task automatic write_cell(input int inst, input int addr, input logic [7:0] data);
      wr_en[inst]   = 1'b1;
      wr_addr[inst] = 7'(addr);
      wr_data[inst] = data;
      @(posedge clk_i); #1;
      wr_en[inst] = 1'b0;
      if (addr < rows_of(inst) * cols_of(inst)) mem[inst][addr] = data;
   endtask

   task automatic pulse_refresh(input int inst);
      refresh[inst] = 1'b1;
      @(posedge clk_i); #1;
      refresh[inst] = 1'b0;
   endtask

   task automatic run_frame(input int inst, input string tag, input int target);
      logic [9:0] exp_q[$];
      logic [9:0] got_q[$];
      int cyc;
      build_frame(inst, exp_q);
      cyc = 0;
      while (done_cnt[inst] < target && cyc < 5000) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check({tag, " done"}, 32'(cyc < 5000), 32'd1);
      check({tag, " busy"}, 32'(busy[inst]), 32'd0);
      if (inst == 0) got_q = log_a;
      else           got_q = log_b;
      check({tag, " len"}, got_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      clear_log(inst);
   endtask

   task automatic settle(input int inst, output int frames);
      int base;
      int quiet;
      int cyc;
      base  = done_cnt[inst];
      quiet = 0;
      cyc   = 0;
      while (quiet < 20 && cyc < 5000) begin
         @(posedge clk_i); #1;
         cyc++;
         if (busy[inst]) quiet = 0;
         else            quiet++;
      end
      check("settle bound", 32'(cyc < 5000), 32'd1);
      frames = done_cnt[inst] - base;
      clear_log(inst);
   endtask

   task automatic check_settle(input int inst, input string tag);
      int frames;
      settle(inst, frames);
`ifdef LCD_TEXT_AUTO_REFRESH_EN
      check({tag, " auto frames"}, 32'(frames >= 1), 32'd1);
`else
      check({tag, " no auto frame"}, frames, 32'd0);
`endif
   endtask

   task automatic wait_log_a(input int n, input string tag);
      int cyc;
      cyc = 0;
      while (log_a.size() < n && cyc < 5000) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check(tag, 32'(cyc < 5000), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int frames;
      int cyc;
      for (int i = 0; i < 2; i++) begin
         wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
         refresh[i] = 1'b0; hold[i] = 1'b0;
         for (int k = 0; k < 80; k++) mem[i][k] = 8'h20;
      end

      // Clock/reset.
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst busy%0d", i), 32'(busy[i]), 32'd0);
         check($sformatf("rst done%0d", i), 32'(done[i]), 32'd0);
         check($sformatf("rst enb%0d", i), 32'(enb[i]), 32'd0);
         check($sformatf("rst data%0d", i), 32'(ldata[i]), 32'd0);
         check($sformatf("rst ops%0d", i), 32'(lops[i]), 32'd0);
      end
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Power-up blank frame on the 4x20 build: commands 80/C0/94/D4, 84 transactions.
      pulse_refresh(1);
      run_frame(1, "b blank", done_cnt[1] + 1);

      // "HI" on the 2x16 build.
      write_cell(0, 0, 8'h48);
      write_cell(0, 1, 8'h49);
      check_settle(0, "hi");
      pulse_refresh(0);
      run_frame(0, "hi", done_cnt[0] + 1);

      // Randomized contents, including the last cell.
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < int'($urandom_range(1, 6)); k++)
            write_cell(0, int'($urandom_range(0, 31)), 8'($urandom_range(8'h21, 8'h7e)));
         write_cell(0, 31, 8'($urandom_range(8'h21, 8'h7e)));
         check_settle(0, "rand");
         pulse_refresh(0);
         run_frame(0, $sformatf("rand%0d", f), done_cnt[0] + 1);
      end
      for (int k = 0; k < 8; k++)
         write_cell(1, int'($urandom_range(0, 79)), 8'($urandom_range(8'h21, 8'h7e)));
      write_cell(1, 79, 8'h7e);
      check_settle(1, "b rand");
      pulse_refresh(1);
      run_frame(1, "b rand", done_cnt[1] + 1);

      // Out-of-range writes change nothing and schedule nothing.
      write_cell(1, 80, 8'h41);
      write_cell(1, 127, 8'h41);
      settle(1, frames);
      check("oor no frame", frames, 32'd0);
      pulse_refresh(1);
      run_frame(1, "b oor", done_cnt[1] + 1);

      // Three requests while busy collapse into one more frame.
      base = done_cnt[0];
      pulse_refresh(0);
      repeat (10) @(posedge clk_i);
      #1;
      for (int k = 0; k < 3; k++) begin
         pulse_refresh(0);
         repeat (int'($urandom_range(5, 30))) @(posedge clk_i);
         #1;
      end
      run_frame(0, "collapse1", base + 1);
      run_frame(0, "collapse2", base + 2);
      repeat (300) @(posedge clk_i);
      #1;
      check("collapse count", done_cnt[0], base + 2);
      check("collapse idle", 32'(busy[0]), 32'd0);
      check("collapse quiet", log_a.size(), 32'd0);

      // A request in the DONE cycle still gives one more frame.
      base = done_cnt[0];
      pulse_refresh(0);
      cyc = 0;
      while (!done[0] && cyc < 5000) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check("done seen", 32'(done[0]), 32'd1);
      pulse_refresh(0);
      run_frame(0, "done req1", base + 1);
      run_frame(0, "done req2", base + 2);

      // Write to cell 17 on the very cycle it is issued: old value goes out, new value next frame.
      write_cell(0, 17, 8'h20);
      check_settle(0, "pre17");
      base = done_cnt[0];
      pulse_refresh(0);
      wait_log_a(19, "reach cell16");
      hold[0] = 1'b1;
      repeat (8) @(posedge clk_i);
      @(negedge clk_i);
      hold[0] = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i); #1;
      wr_en[0] = 1'b1; wr_addr[0] = 7'd17; wr_data[0] = 8'h5a;
      @(posedge clk_i); #1;
      wr_en[0] = 1'b0;
      run_frame(0, "same-cycle", base + 1);
      mem[0][17] = 8'h5a;
`ifdef LCD_TEXT_AUTO_REFRESH_EN
      @(posedge clk_i); #1;
      check("auto restart", 32'(busy[0]), 32'd1);
      run_frame(0, "auto frame", base + 2);
`else
      repeat (200) @(posedge clk_i);
      #1;
      check("no auto restart", done_cnt[0], base + 1);
      check("no auto tx", log_a.size(), 32'd0);
      pulse_refresh(0);
      run_frame(0, "after write", base + 2);
`endif

      // Reset while enb is high in row 1 abandons the frame for good.
      base = done_cnt[0];
      pulse_refresh(0);
      wait_log_a(20, "reach row1");
      cyc = 0;
      while (!enb[0] && cyc < 100) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check("enb high row1", 32'(enb[0]), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rst enb drop", 32'(enb[0]), 32'd0);
      check("rst busy drop", 32'(busy[0]), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      clear_log(0);
      repeat (200) @(posedge clk_i);
      #1;
      check("post-rst no done", done_cnt[0], base);
      check("post-rst no tx", log_a.size(), 32'd0);
      check("post-rst idle", 32'(busy[0]), 32'd0);
      pulse_refresh(0);
      run_frame(0, "recover", base + 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
